// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the shared data memory unit.
// Optional MEM_ARB_CPU_PRIORITY_EN: fixed port 0 priority with port 1 starve limit.
module mem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req0_i,
  input  logic [ADDRESS_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0]    wdata0_i,
  input  logic [2:0]               ctrl0_i,
  input  logic                     we0_i,
  output logic                     gnt0_o,
  output logic                     rvalid0_o,
  output logic [DATA_WIDTH-1:0]    rdata0_o,
  input  logic                     req1_i,
  input  logic [ADDRESS_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0]    wdata1_i,
  input  logic [2:0]               ctrl1_i,
  input  logic                     we1_i,
  output logic                     gnt1_o,
  output logic                     rvalid1_o,
  output logic [DATA_WIDTH-1:0]    rdata1_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  output logic [2:0]               mem_ctrl_o,
  output logic                     mem_we_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be 1..15");
  end

  logic                     pick1;
  logic                     gnt0;
  logic                     gnt1;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [2:0]               ctrl_q;
  logic                     we_q;
  logic                     valid_q;
  logic                     owner_q;

`ifdef MEM_ARB_CPU_PRIORITY_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;

  // Port 1 only wins contention once it has lost LIMIT times in a row.
  always_comb begin
    pick1 = req1_i & (~req0_i | (starve_q == LIMIT));
  end

  // Count consecutive contended losses of port 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else if (gnt1 | ~req1_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_q + 4'd1;
    end
  end
`else
  logic last_q;

  // Round-robin: on contention grant the port that did not win last.
  always_comb begin
    pick1 = req1_i & (~req0_i | ~last_q);
  end

  // Remember the last winner; reset to 1 so port 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (gnt0 | gnt1) begin
      last_q <= gnt1;
    end
  end
`endif

  // Grants are suppressed during reset so held requests stay pending.
  always_comb begin
    gnt0 = req0_i & ~pick1 & ~rst_i;
    gnt1 = pick1 & ~rst_i;
  end

  // Capture the winner's fields into the issue register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ctrl_q  <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      owner_q <= 1'b0;
    end else if (gnt0 | gnt1) begin
      addr_q  <= gnt1 ? addr1_i  : addr0_i;
      wdata_q <= gnt1 ? wdata1_i : wdata0_i;
      ctrl_q  <= gnt1 ? ctrl1_i  : ctrl0_i;
      we_q    <= gnt1 ? we1_i    : we0_i;
      valid_q <= 1'b1;
      owner_q <= gnt1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  // Drive the memory unit and route the response to the owner.
  always_comb begin
    gnt0_o      = gnt0;
    gnt1_o      = gnt1;
    mem_addr_o  = rst_i ? '0 : addr_q;
    mem_wdata_o = rst_i ? '0 : wdata_q;
    mem_ctrl_o  = rst_i ? '0 : ctrl_q;
    mem_we_o    = we_q & valid_q & ~rst_i;
    rvalid0_o   = valid_q & ~owner_q & ~rst_i;
    rvalid1_o   = valid_q & owner_q & ~rst_i;
    rdata0_o    = (~owner_q & ~rst_i) ? mem_rdata_i : '0;
    rdata1_o    = (owner_q & ~rst_i) ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory stub, directed stimulus,
// expected-response queue and a decoupled monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fill = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [2:0]  ctrl0 = '0, ctrl1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;
  logic        mem_we;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic        we;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .addr0_i(addr0), .wdata0_i(wdata0),
    .ctrl0_i(ctrl0), .we0_i(we0), .gnt0_o(gnt0),
    .rvalid0_o(rvalid0), .rdata0_o(rdata0),
    .req1_i(req1), .addr1_i(addr1), .wdata1_i(wdata1),
    .ctrl1_i(ctrl1), .we1_i(we1), .gnt1_o(gnt1),
    .rvalid1_o(rvalid1), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ctrl_o(mem_ctrl), .mem_we_o(mem_we),
    .mem_rdata_i(mem_rdata)
  );

  // Memory stub: word i holds 5A5A5A_i, except word 4 = DEADBEEF.
  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= {24'h5A5A5A, 8'(i)};
      mem[4] <= 32'hDEADBEEF;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per response cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_outs",
          {27'd0, gnt0, gnt1, mem_we, rvalid0, rvalid1}, 32'd0);
    end else if (rvalid0 || rvalid1) begin
      if (q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("rv_port", {30'd0, rvalid1, rvalid0},
            e.port ? 32'd2 : 32'd1);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
        if (e.we) begin
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_ctrl", {29'd0, mem_ctrl}, {29'd0, e.ctrl});
        end else if (e.port) begin
          chk("rdata1", rdata1, e.rdata);
          chk("rdata0_idle", rdata0, 32'd0);
        end else begin
          chk("rdata0", rdata0, e.rdata);
          chk("rdata1_idle", rdata1, 32'd0);
        end
      end
    end else begin
      chk("idle_we", {31'd0, mem_we}, 32'd0);
    end
  end

  task automatic drive(input bit p, input bit r,
                       input logic [31:0] a,
                       input logic [31:0] w,
                       input logic [2:0] c, input bit we);
    if (p) begin
      req1 = r; addr1 = a; wdata1 = w; ctrl1 = c; we1 = we;
    end else begin
      req0 = r; addr0 = a; wdata0 = w; ctrl0 = c; we0 = we;
    end
  endtask

  function automatic exp_t mk(input bit p,
                              input logic [31:0] a,
                              input logic [31:0] w,
                              input logic [2:0] c, input bit we,
                              input logic [31:0] rd);
    exp_t e;
    e.port = p; e.addr = a; e.wdata = w;
    e.ctrl = c; e.we = we; e.rdata = rd;
    return e;
  endfunction

  // Single request; waits for grant, optionally records expectation.
  task automatic issue(input bit p, input logic [31:0] a,
                       input logic [31:0] w, input logic [2:0] c,
                       input bit we, input logic [31:0] rd,
                       input bit keep, input bit rst_after);
    int n = 0;
    @(posedge clk); #1;
    drive(p, 1'b1, a, w, c, we);
    forever begin
      @(negedge clk);
      if (p ? gnt1 : gnt0) break;
      n++;
      if (n > 10) begin
        total++; bad++;
        $display("FAIL gnt_timeout port=%0d actual=none required=grant", p);
        break;
      end
      @(posedge clk); #1;
    end
    chk("gnt_latency", n, 0);
    chk("gnt_other", {31'd0, p ? gnt0 : gnt1}, 32'd0);
    if (keep) q.push_back(mk(p, a, w, c, we, rd));
    @(posedge clk); #1;
    drive(p, 1'b0, '0, '0, '0, 1'b0);
    if (rst_after) rst = 1'b1;
  endtask

`ifdef MEM_ARB_CPU_PRIORITY_EN
  localparam int LEN = 12;
  int pat [LEN] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
`else
  localparam int LEN = 6;
  int pat [LEN] = '{0, 1, 0, 1, 0, 1};
`endif

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fill = 1'b0;

    issue(0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF, 1, 0);
    issue(1, 32'h24, 32'hAB, 3'b000, 1, 32'h0, 1, 0);

    // Contended stream: both ports hold reads.
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h30, 32'h0, 3'b010, 1'b0);
    drive(1, 1'b1, 32'h34, 32'h0, 3'b010, 1'b0);
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      chk("both_gnt", {31'd0, gnt0 & gnt1}, 32'd0);
      chk("pattern", {30'd0, gnt1, gnt0},
          pat[k] ? 32'd2 : 32'd1);
      if (pat[k] != 0)
        q.push_back(mk(1, 32'h34, 0, 3'b010, 0, 32'h5A5A5A0D));
      else
        q.push_back(mk(0, 32'h30, 0, 3'b010, 0, 32'h5A5A5A0C));
      @(posedge clk); #1;
    end
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    drive(1, 1'b0, '0, '0, '0, 1'b0);

    // Write to 0x40 lost by reset in the issue cycle.
    issue(0, 32'h40, 32'h12345678, 3'b010, 1, 32'h0, 0, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while both ports request; port 0 wins right after.
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b1, 32'h40, 32'h0, 3'b010, 1'b0);
    drive(1, 1'b1, 32'h24, 32'h0, 3'b010, 1'b0);
    @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_gnt0", {31'd0, gnt0}, 32'd1);
    chk("post_rst_gnt1", {31'd0, gnt1}, 32'd0);
    q.push_back(mk(0, 32'h40, 0, 3'b010, 0, 32'h5A5A5A10));
    @(posedge clk); #1;
    drive(0, 1'b0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("post_rst_gnt1b", {31'd0, gnt1}, 32'd1);
    q.push_back(mk(1, 32'h24, 0, 3'b010, 0, 32'h000000AB));
    @(posedge clk); #1;
    drive(1, 1'b0, '0, '0, '0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
